// File: rtl/s32x_md_sync_gen.sv
// Mega Drive VDP-side video timing source for the 32X video block.
// Generates EDCLK, syncs, YS_N and exports dot/line position and blanking.
module s32x_md_sync_gen #(
    parameter int HSW_H40      = 36,
    parameter int HSW_H32      = 26,
    parameter int LINES_NTSC   = 262,
    parameter int LINES_PAL    = 313,
    parameter int VS_LINE_NTSC = 235,
    parameter int VS_LINE_PAL  = 259,
    parameter int VS_LEN       = 3,
    parameter int ACT_V28      = 224,
    parameter int ACT_V30      = 240
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       H40,
    input  logic       PAL,
    input  logic       V30,
    input  logic       BG_TRANSP,
    output logic       EDCLK,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       YS_N,
    output logic       DOT_CE,
    output logic [8:0] H_POS,
    output logic [8:0] V_POS,
    output logic       HDISP,
    output logic       VBLANK
);

    localparam logic [8:0] HLAST_H40 = 9'd419;
    localparam logic [8:0] HLAST_H32 = 9'd341;
    localparam logic [8:0] HSW40     = 9'(HSW_H40);
    localparam logic [8:0] HSW32     = 9'(HSW_H32);
    localparam logic [8:0] VLAST_N   = 9'(LINES_NTSC - 1);
    localparam logic [8:0] VLAST_P   = 9'(LINES_PAL - 1);
    localparam logic [8:0] VS0_N     = 9'(VS_LINE_NTSC);
    localparam logic [8:0] VS1_N     = 9'(VS_LINE_NTSC + VS_LEN);
    localparam logic [8:0] VS0_P     = 9'(VS_LINE_PAL);
    localparam logic [8:0] VS1_P     = 9'(VS_LINE_PAL + VS_LEN);
    localparam logic [8:0] ACT28     = 9'(ACT_V28);
    localparam logic [8:0] ACT30     = 9'(ACT_V30);

    logic [3:0] tick_q, tick_d;
    logic [8:0] h_q, h_d, v_q, v_d;
    logic       first_q, first_d;
    logic       h40_q, h40_d, pal_q, pal_d, v30_q, v30_d;
    logic       edclk_q, edclk_d, hs_q, hs_d, vs_q, vs_d, ys_q, ys_d;
    logic       dce_q, dce_d, hd_q, hd_d, vb_q, vb_d;

    logic       dot_end;
    logic [8:0] h_last, v_last, vs_lo, vs_hi, act_lines;

    always_comb begin
        tick_d    = tick_q;
        h_d       = h_q;
        v_d       = v_q;
        first_d   = first_q;
        h40_d     = h40_q;
        pal_d     = pal_q;
        v30_d     = v30_q;
        edclk_d   = edclk_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        ys_d      = ys_q;
        hd_d      = hd_q;
        vb_d      = vb_q;
        vs_lo     = 9'd0;
        vs_hi     = 9'd0;
        act_lines = 9'd0;

        dot_end = CE && (tick_q == (h40_q ? 4'd7 : 4'd9));
        h_last  = h40_q ? HLAST_H40 : HLAST_H32;
        v_last  = pal_q ? VLAST_P : VLAST_N;
        dce_d   = dot_end;

        if (CE) begin
            tick_d = tick_q + 4'd1;
            if (dot_end) begin
                tick_d  = 4'd0;
                first_d = 1'b0;
                // first_q marks the post-reset "last dot of last line" state
                if (first_q || h_q == h_last) begin
                    h_d = 9'd0;
                    v_d = (first_q || v_q == v_last) ? 9'd0 : v_q + 9'd1;
                end else begin
                    h_d = h_q + 9'd1;
                end
                if (h_d == 9'd0) h40_d = H40;
                if (h_d == 9'd0 && v_d == 9'd0) begin
                    pal_d = PAL;
                    v30_d = V30;
                end

                vs_lo     = pal_d ? VS0_P : VS0_N;
                vs_hi     = pal_d ? VS1_P : VS1_N;
                act_lines = (pal_d && v30_d) ? ACT30 : ACT28;

                hs_d = !(h_d < (h40_d ? HSW40 : HSW32));
                vs_d = !(v_d >= vs_lo && v_d < vs_hi);
                vb_d = (v_d >= act_lines);
                hd_d = h40_d ? (h_d >= 9'd64 && h_d <= 9'd383)
                             : (h_d >= 9'd48 && h_d <= 9'd303);
                ys_d = (hd_d && !vb_d) ? !BG_TRANSP : 1'b1;
            end
            // two EDCLK periods per dot; H32 stretches the high phases to 3 ticks
            if (h40_d)
                edclk_d = (tick_d <= 4'd1) || (tick_d >= 4'd4 && tick_d <= 4'd5);
            else
                edclk_d = (tick_d <= 4'd2) || (tick_d >= 4'd5 && tick_d <= 4'd7);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q  <= 4'd9;
            h_q     <= 9'd0;
            v_q     <= 9'd0;
            first_q <= 1'b1;
            h40_q   <= 1'b0;
            pal_q   <= 1'b0;
            v30_q   <= 1'b0;
            edclk_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            ys_q    <= 1'b1;
            dce_q   <= 1'b0;
            hd_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            h_q     <= h_d;
            v_q     <= v_d;
            first_q <= first_d;
            h40_q   <= h40_d;
            pal_q   <= pal_d;
            v30_q   <= v30_d;
            edclk_q <= edclk_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ys_q    <= ys_d;
            dce_q   <= dce_d;
            hd_q    <= hd_d;
            vb_q    <= vb_d;
        end
    end

    assign EDCLK   = edclk_q;
    assign HSYNC_N = hs_q;
    assign VSYNC_N = vs_q;
    assign YS_N    = ys_q;
    assign DOT_CE  = dce_q;
    assign H_POS   = h_q;
    assign V_POS   = v_q;
    assign HDISP   = hd_q;
    assign VBLANK  = vb_q;

endmodule
